// File: rtl/psum_ofifo.sv
// rtl/psum_ofifo.sv - per-column partial-sum FIFOs that deskew the array's south outputs into aligned rows
// Columns fill independently as their valids arrive; a read pops one entry from every column at once.
module psum_ofifo #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_overflow
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

  logic [col-1:0]              empty_v;
  logic [col-1:0]              full_v;
  logic [col-1:0][psum_bw-1:0] rd_row;
  logic                        rd_accept;

  // Status comes only from registered pointers, so wr/rd never reach it combinationally.
  assign o_ready   = &(~empty_v);
  assign o_full    = |full_v;
  assign rd_accept = rd && o_ready;

  for (genvar c = 0; c < col; c++) begin : g_col
    logic [psum_bw-1:0] mem [depth];
    logic [aw:0]        wptr;
    logic [aw:0]        rptr;
    logic               do_wr;

    assign empty_v[c] = (wptr == rptr);
    assign full_v[c]  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
    // A full column still accepts a write when this cycle's read frees a slot.
    assign do_wr      = wr[c] && (!full_v[c] || rd_accept);
    assign rd_row[c]  = mem[rptr[aw-1:0]];

    always_ff @(posedge clk) begin
      if (reset) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_wr) wptr <= wptr + ptr_one;
        if (rd_accept) rptr <= rptr + ptr_one;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset && do_wr) mem[wptr[aw-1:0]] <= in[psum_bw*c +: psum_bw];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= rd_accept;
      if (rd_accept) out <= rd_row;
      if (|(wr & full_v) && !rd_accept) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// tb/tb_psum_ofifo.sv - randomized scoreboard bench for psum_ofifo
// Per-column queues model the buffers; a negedge monitor checks status and popped rows.
module tb_psum_ofifo;
  localparam int PW    = 16;
  localparam int COL   = 8;
  localparam int DEPTH = 64;
  localparam int W     = PW * COL;

  typedef logic [PW-1:0] pq_t[$];

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   din = '0;
  logic [COL-1:0] wr = '0;
  logic           rd = 1'b0;
  logic [W-1:0]   dout;
  logic           o_valid, o_ready, o_full, o_overflow;

  int checks = 0;
  int failures = 0;

  pq_t          mq [COL];
  logic [W-1:0] sb [$];
  logic [W-1:0] exp_out = '0;
  logic         exp_valid = 1'b0;
  logic         exp_ready = 1'b0;
  logic         exp_full = 1'b0;
  logic         exp_ovf = 1'b0;
  logic         mon_en = 1'b0;

  psum_ofifo #(.psum_bw(PW), .col(COL), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd),
    .out(dout), .o_valid(o_valid), .o_ready(o_ready),
    .o_full(o_full), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[c*PW +: PW] = PW'($urandom);
    return r;
  endfunction

  // Drive one cycle, then advance the reference model by that cycle's rules.
  task automatic step(input logic rst, input logic [COL-1:0] w, input logic r, input logic [W-1:0] d);
    logic         rdy;
    logic         acc;
    logic [W-1:0] row;
    reset = rst; wr = w; rd = r; din = d;
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < COL; c++) mq[c].delete();
      exp_valid = 1'b0;
      exp_out   = '0;
      exp_ovf   = 1'b0;
    end else begin
      rdy = 1'b1;
      for (int c = 0; c < COL; c++) if (mq[c].size() == 0) rdy = 1'b0;
      acc = r && rdy;
      if (acc) begin
        for (int c = 0; c < COL; c++) row[c*PW +: PW] = mq[c].pop_front();
        sb.push_back(row);
        exp_out = row;
      end
      for (int c = 0; c < COL; c++)
        if (w[c]) begin
          if (mq[c].size() < DEPTH) mq[c].push_back(d[c*PW +: PW]);
          else exp_ovf = 1'b1;
        end
      exp_valid = acc;
    end
    exp_ready = 1'b1;
    exp_full  = 1'b0;
    for (int c = 0; c < COL; c++) begin
      if (mq[c].size() == 0) exp_ready = 1'b0;
      if (mq[c].size() == DEPTH) exp_full = 1'b1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("o_valid", W'(o_valid), W'(exp_valid));
      chk("o_ready", W'(o_ready), W'(exp_ready));
      chk("o_full", W'(o_full), W'(exp_full));
      chk("o_overflow", W'(o_overflow), W'(exp_ovf));
      if (o_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL row_unexpected actual=%h required=none", dout);
        end else begin
          chk("row", dout, sb.pop_front());
        end
      end else begin
        chk("out_hold", dout, exp_out);
      end
    end
  end

  initial begin
    logic [W-1:0] r_row;
    logic [W-1:0] skew;

    // Reset with random strobes must leave everything cleared.
    for (int i = 0; i < 3; i++) step(1'b1, COL'($urandom), 1'($urandom), rand_row());
    mon_en = 1'b1;
    chk("reset_out", dout, '0);
    chk("reset_ready", W'(o_ready), '0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, rand_row());

    // Skewed single row: column c arrives c cycles after column 0.
    for (int c = 0; c < COL; c++) begin
      skew = '0;
      skew[c*PW +: PW] = PW'(16'h0100 + c);
      step(1'b0, COL'(1) << c, 1'b0, skew);
      if (c < COL - 1) chk("skew_not_ready", W'(o_ready), '0);
    end
    chk("skew_ready", W'(o_ready), W'(1));
    step(1'b0, '0, 1'b1, '0);
    chk("skew_row", dout, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    chk("skew_drained", W'(o_ready), '0);

    // Fill to full, then read+write in the same cycle while full.
    for (int i = 0; i < DEPTH; i++) step(1'b0, '1, 1'b0, rand_row());
    chk("fill_full", W'(o_full), W'(1));
    r_row = rand_row();
    step(1'b0, '1, 1'b1, r_row);
    chk("rw_full_stays", W'(o_full), W'(1));
    chk("rw_no_overflow", W'(o_overflow), '0);
    step(1'b0, COL'(8'b0000_1000), 1'b0, rand_row());
    chk("overflow_set", W'(o_overflow), W'(1));
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, rand_row());
    chk("last_is_r", dout, r_row);
    chk("overflow_sticky", W'(o_overflow), W'(1));
    step(1'b0, '0, 1'b1, '0);
    chk("drained", W'(o_ready), '0);

    // Seven of eight columns present: reads must be ignored.
    step(1'b0, COL'(8'h7f), 1'b0, rand_row());
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, rand_row());
    step(1'b0, COL'(8'h80), 1'b0, rand_row());
    step(1'b0, '0, 1'b1, '0);
    step(1'b0, '0, 1'b0, '0);

    // Random streaming with wrap-around and a reset in the middle.
    for (int i = 0; i < 700; i++) begin
      if (i == 350) begin
        step(1'b1, COL'($urandom), 1'($urandom), rand_row());
        chk("midreset_ready", W'(o_ready), '0);
        chk("midreset_full", W'(o_full), '0);
        chk("midreset_out", dout, '0);
      end else begin
        logic [COL-1:0] w;
        for (int c = 0; c < COL; c++) w[c] = ($urandom_range(0, 3) != 0);
        step(1'b0, w, ($urandom_range(0, 2) != 0), rand_row());
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0);
    chk("sb_empty", W'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
